// File: rtl/apb_master_fsm.sv
// APB4 requester stage of the AXI-to-APB bridge: pops merged requests, runs
// SETUP/ACCESS transfers and pushes one response per transfer, with a wait-state timeout.
module apb_master_fsm #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Timeout   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_empty,
  output logic                   req_pop,
  input  logic                   req_write,
  input  logic [AddrWidth-1:0]   req_addr,
  input  logic [DataWidth-1:0]   req_wdata,
  input  logic [DataWidth/8-1:0] req_strb,
  input  logic [2:0]             req_prot,
  input  logic                   rsp_full,
  input  logic                   rsp_almost_full,
  output logic                   rsp_push,
  output logic                   rsp_write,
  output logic [DataWidth-1:0]   rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [AddrWidth-1:0]   paddr,
  output logic [DataWidth-1:0]   pwdata,
  output logic [DataWidth/8-1:0] pstrb,
  output logic [2:0]             pprot,
  input  logic                   pready,
  input  logic                   pslverr,
  input  logic [DataWidth-1:0]   prdata
);

  localparam int unsigned CntWidth = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [CntWidth-1:0] CntLast = (Timeout > 0) ? CntWidth'(Timeout - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state, state_nxt;
  logic [CntWidth-1:0]   cnt, cnt_nxt;
  logic                  psel_nxt, penable_nxt;
  logic                  load;
  logic                  start_ok, chain_ok;
  logic                  timed_out;

  // The response slot is reserved at start: full gates a fresh start, almost_full gates chaining.
  assign start_ok = !req_empty && !rsp_full;
  assign chain_ok = !req_empty && !rsp_almost_full;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    psel_nxt    = psel;
    penable_nxt = penable;
    load        = 1'b0;
    timed_out   = 1'b0;
    rsp_push    = 1'b0;
    rsp_resp    = 2'b00;
    case (state)
      IDLE: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        cnt_nxt     = '0;
        if (start_ok) begin
          load      = 1'b1;
          state_nxt = SETUP;
          psel_nxt  = 1'b1;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        timed_out = (Timeout != 0) && !pready && (cnt == CntLast);
        if (pready || timed_out) begin
          rsp_push = 1'b1;
          rsp_resp = ((pready && pslverr) || timed_out) ? 2'b10 : 2'b00;
          cnt_nxt  = '0;
          if (chain_ok) begin
            load        = 1'b1;
            state_nxt   = SETUP;
            penable_nxt = 1'b0;
          end else begin
            state_nxt   = IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  // Pop is combinational off the request FIFO flags, so it must be masked while reset is held.
  assign req_pop   = load && reset_n;
  assign rsp_write = pwrite;
  assign rsp_rdata = (!pwrite && pready) ? prdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      psel    <= psel_nxt;
      penable <= penable_nxt;
      if (load) begin
        pwrite <= req_write;
        paddr  <= req_addr;
        pwdata <= req_write ? req_wdata : '0;
        pstrb  <= req_write ? req_strb : '0;
        pprot  <= req_prot;
      end
    end
  end

endmodule
